// File: rtl/axi_spi_top_if.sv
// AXI4-Lite bus bundle for axi_spi_top.
//  master modport: interconnect / CPU side (drives addresses, data, VALIDs, BREADY/RREADY)
//  slave  modport: axi_spi_top side (drives AWREADY/WREADY/ARREADY, BVALID/BRESP, RVALID/RDATA/RRESP)
interface axi_spi_top_if;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_spi_top.sv
// axi_spi_top: AXI4-Lite slave wrapping a single-byte SPI master (mode 0, MSB first).
//  ACLK      : clock, all state on its rising edge
//  ARESETn   : synchronous reset, ACTIVE HIGH despite the name (ARESETn=1 resets)
//  bus       : AXI4-Lite slave port (axi_spi_top_if.slave)
//  SPI_SCK   : serial clock out, idles low
//  SPI_MOSI  : serial data out, idles low
//  SPI_MISO  : serial data in, sampled on SCK rising edges
// Register map: 0x0 DATA (W: TX byte + start, R: RX byte, clears DONE),
//               0x4 STAT (R: bit0 BUSY, bit1 DONE), 0x8 CTRL (R/W: [7:0] DIV).
module axi_spi_top #(
  parameter logic [7:0] DIV_DEFAULT = 8'd4
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  axi_spi_top_if.slave  bus,
  output logic          SPI_MOSI,
  input  logic          SPI_MISO,
  output logic          SPI_SCK
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {REG_DATA, REG_STAT, REG_CTRL, REG_NONE} reg_sel_e;
  typedef enum logic {S_IDLE, S_SHIFT} spi_state_e;

  function automatic reg_sel_e decode(input logic [31:0] addr);
    if (addr[31:4] != '0 || addr[1:0] != 2'b00) return REG_NONE;
    case (addr[3:2])
      2'd0:    return REG_DATA;
      2'd1:    return REG_STAT;
      2'd2:    return REG_CTRL;
      default: return REG_NONE;
    endcase
  endfunction

  // Bus-side state
  logic       aw_ready_q;
  logic       b_valid_q;
  logic [1:0] b_resp_q;
  logic       ar_ready_q;
  logic       r_valid_q;
  logic [31:0] r_data_q;
  logic [1:0] r_resp_q;

  // Register file
  logic [7:0] div_q;
  logic [7:0] rx_q;
  logic       done_q;

  // SPI engine
  spi_state_e state_q, state_d;
  logic [7:0] tx_sh_q;
  logic [7:0] rx_sh_q;
  logic [7:0] div_lat_q;
  logic [7:0] div_cnt_q;
  logic [3:0] half_cnt_q;
  logic       sck_q;
  logic       mosi_q;

  // Fields the block does not use; kept visible so the omission is deliberate.
  logic unused_bits;
  assign unused_bits = ^{bus.AWPROT, bus.ARPROT, bus.WDATA[31:8], bus.WSTRB[3:1]};

  assign bus.AWREADY = aw_ready_q;
  assign bus.WREADY  = aw_ready_q;
  assign bus.BVALID  = b_valid_q;
  assign bus.BRESP   = b_resp_q;
  assign bus.ARREADY = ar_ready_q;
  assign bus.RVALID  = r_valid_q;
  assign bus.RDATA   = r_data_q;
  assign bus.RRESP   = r_resp_q;
  assign SPI_SCK     = sck_q;
  assign SPI_MOSI    = mosi_q;

  // Decode and handshake qualifiers
  reg_sel_e   wr_sel, rd_sel;
  logic       wr_fire, rd_fire, busy, start, half_tick, last_edge;
  logic [1:0] wr_resp;
  logic [31:0] rd_data;

  assign wr_sel    = decode(bus.AWADDR);
  assign rd_sel    = decode(bus.ARADDR);
  assign wr_fire   = aw_ready_q && bus.AWVALID && bus.WVALID;
  assign rd_fire   = ar_ready_q && bus.ARVALID;
  assign busy      = (state_q == S_SHIFT);
  // A DATA write only launches when the TX lane is enabled and the engine is free.
  assign start     = wr_fire && (wr_sel == REG_DATA) && bus.WSTRB[0] && !busy;
  assign half_tick = busy && (div_cnt_q == div_lat_q);
  // Half-period 15 is always a falling SCK edge: the end of the transfer.
  assign last_edge = half_tick && (half_cnt_q == 4'd15);

  always_comb begin
    wr_resp = RESP_OKAY;
    if (wr_sel == REG_NONE)                                     wr_resp = RESP_SLVERR;
    else if (wr_sel == REG_DATA && bus.WSTRB[0] && busy)        wr_resp = RESP_SLVERR;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    rd_data = '0;
    case (rd_sel)
      REG_DATA: rd_data = {24'd0, rx_q};
      REG_STAT: rd_data = {30'd0, done_q, busy};
      REG_CTRL: rd_data = {24'd0, div_q};
      default:  rd_data = '0;
    endcase
  end

  // Write and read channels. The READY pulse is self-clearing so each
  // transaction is accepted exactly once, even if VALID stays high.
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (ARESETn) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      aw_ready_q <= bus.AWVALID && bus.WVALID && !b_valid_q && !aw_ready_q;
      if (wr_fire) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_resp;
      end else if (b_valid_q && bus.BREADY) begin
        b_valid_q <= 1'b0;
      end

      ar_ready_q <= bus.ARVALID && !r_valid_q && !ar_ready_q;
      if (rd_fire) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_data;
        r_resp_q  <= (rd_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (r_valid_q && bus.RREADY) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  // CTRL and DONE. A completing transfer beats a simultaneous DATA read clear.
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      div_q  <= DIV_DEFAULT;
      done_q <= 1'b0;
    end else begin
      if (wr_fire && wr_sel == REG_CTRL && bus.WSTRB[0]) div_q <= bus.WDATA[7:0];
      if (last_edge)                                     done_q <= 1'b1;
      else if (rd_fire && rd_sel == REG_DATA)            done_q <= 1'b0;
    end
  end

  // SPI engine state register
  always_ff @(posedge ACLK) begin
    if (ARESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_SHIFT;
      S_SHIFT: if (last_edge) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // SPI datapath. DIV is latched at start so CTRL writes mid-transfer
  // only affect the next byte.
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_q       <= '0;
      div_lat_q  <= '0;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else if (start) begin
      tx_sh_q    <= bus.WDATA[7:0];
      rx_sh_q    <= '0;
      div_lat_q  <= div_q;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= bus.WDATA[7];
    end else if (busy) begin
      if (half_tick) begin
        div_cnt_q  <= '0;
        half_cnt_q <= half_cnt_q + 4'd1;
        if (!sck_q) begin
          sck_q   <= 1'b1;
          rx_sh_q <= {rx_sh_q[6:0], SPI_MISO};
        end else begin
          sck_q <= 1'b0;
          if (half_cnt_q == 4'd15) begin
            mosi_q <= 1'b0;
            rx_q   <= rx_sh_q;
          end else begin
            mosi_q  <= tx_sh_q[6];
            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
          end
        end
      end else begin
        div_cnt_q <= div_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_spi_top.sv
// Directed testbench for axi_spi_top: AXI-Lite register access, SPI timing,
// MOSI bit order, RX capture, error responses and reset abort.
module tb_axi_spi_top;

  logic ACLK;
  logic ARESETn;
  logic SPI_MOSI, SPI_MISO, SPI_SCK;

  axi_spi_top_if bus ();

  axi_spi_top #(.DIV_DEFAULT(8'd4)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .bus      (bus),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO),
    .SPI_SCK  (SPI_SCK)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  time hs_time;

  // SPI pin monitors
  logic mosi_q[$];
  time  edge_t[$];
  always @(posedge SPI_SCK) mosi_q.push_back(SPI_MOSI);
  always @(SPI_SCK) edge_t.push_back($time);

  task automatic clear_mon();
    mosi_q.delete();
    edge_t.delete();
  endtask

  function automatic logic [7:0] mosi_byte();
    logic [7:0] b = 'x;
    if (mosi_q.size() == 8) begin
      for (int i = 0; i < 8; i++) b = {b[6:0], mosi_q[i]};
    end
    return b;
  endfunction

  function automatic bit spacing_ok(input time half);
    bit ok = (edge_t.size() == 16);
    for (int i = 1; i < edge_t.size(); i++)
      if (edge_t[i] - edge_t[i-1] != half) ok = 1'b0;
    return ok;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit got = 0;
    resp = 'x;
    bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.AWREADY === 1'b1) begin got = 1; break; end
    end
    if (got) begin
      @(posedge ACLK); hs_time = $time; #1;
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL write_handshake addr=%h: AWREADY never seen, wanted within 20 cycles", addr);
    end else begin
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge ACLK);
        if (bus.BVALID === 1'b1) begin got = 1; resp = bus.BRESP; break; end
      end
      if (!got) begin
        errors++; $display("FAIL write_bvalid addr=%h: BVALID never seen, wanted within 20 cycles", addr);
      end
      @(posedge ACLK); #1;
    end
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit got = 0;
    data = 'x; resp = 'x;
    bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.ARREADY === 1'b1) begin got = 1; break; end
    end
    if (got) begin
      @(posedge ACLK); #1;
    end
    bus.ARVALID = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL read_handshake addr=%h: ARREADY never seen, wanted within 20 cycles", addr);
    end else begin
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge ACLK);
        if (bus.RVALID === 1'b1) begin got = 1; data = bus.RDATA; resp = bus.RRESP; break; end
      end
      if (!got) begin
        errors++; $display("FAIL read_rvalid addr=%h: RVALID never seen, wanted within 20 cycles", addr);
      end
      @(posedge ACLK); #1;
    end
    bus.RREADY = 1'b0;
  endtask

  // Waits for the 16th SCK edge of the current transfer, then a settling gap.
  task automatic wait_xfer(input string name);
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ACLK);
      if (edge_t.size() >= 16 && SPI_SCK === 1'b0) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s_timeout: saw %0d SCK edges, wanted 16", name, edge_t.size());
    end
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    ARESETn = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.BRESP, bus.RRESP} !== 9'd0) begin
      errors++; $display("FAIL reset_handshake: got %b, wanted 0", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.BRESP, bus.RRESP});
    end
    checks++;
    if ({bus.RDATA, SPI_SCK, SPI_MOSI} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: RDATA=%h SCK=%b MOSI=%b, wanted all 0", bus.RDATA, SPI_SCK, SPI_MOSI);
    end
    @(posedge ACLK); #1 ARESETn = 1'b0;
    axi_read(32'h4, d, r);
    checks++;
    if ({r, d} !== 34'h0) begin errors++; $display("FAIL reset_stat: got resp=%b data=%h, wanted 00/0", r, d); end
    axi_read(32'h8, d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'h4}) begin errors++; $display("FAIL reset_ctrl: got resp=%b data=%h, wanted 00/4", r, d); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic [1:0] r, b;
    SPI_MISO = 1'b0;
    clear_mon();
    fork
      axi_write(32'h0, 32'h0, 4'hF, b);
      axi_read(32'h0, d, r);
    join
    checks++;
    if ({b, r, d} !== 36'h0) begin errors++; $display("FAIL same_cycle: bresp=%b rresp=%b rdata=%h, wanted 00/00/0", b, r, d); end
    wait_xfer("same_cycle");
    checks++;
    if (mosi_q.size() != 8 || mosi_byte() !== 8'h00) begin
      errors++; $display("FAIL same_cycle_sck: pulses=%0d mosi=%h, wanted 8 pulses mosi 00", mosi_q.size(), mosi_byte());
    end
  endtask

  task automatic test_basic_a5();
    logic [31:0] d; logic [1:0] r, b;
    SPI_MISO = 1'b1;
    clear_mon();
    axi_write(32'h0, 32'hA5, 4'h1, b);
    checks++;
    if (b !== 2'b00) begin errors++; $display("FAIL a5_bresp: got %b, wanted 00", b); end
    wait_xfer("a5");
    checks++;
    if (mosi_byte() !== 8'hA5) begin errors++; $display("FAIL a5_mosi: got %h, wanted a5", mosi_byte()); end
    checks++;
    if (!spacing_ok(50) || edge_t[0] - hs_time != 50) begin
      errors++; $display("FAIL a5_halfperiod: edges=%0d first=%0t, wanted 16 edges 50 apart", edge_t.size(), edge_t[0] - hs_time);
    end
    // 16 half-periods of DIV+1=5 cycles: 80 ACLK cycles from launch to the final SCK fall.
    checks++;
    if (edge_t[15] - hs_time != 800) begin
      errors++; $display("FAIL a5_duration: got %0t, wanted 800", edge_t[15] - hs_time);
    end
    axi_read(32'h4, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL a5_stat_done: got %h, wanted 2", d); end
    axi_read(32'h0, d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'hFF}) begin errors++; $display("FAIL a5_rx: got resp=%b data=%h, wanted 00/ff", r, d); end
    axi_read(32'h4, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL a5_stat_clear: got %h, wanted 0", d); end
  endtask

  task automatic test_aw_before_w();
    logic [1:0] first; bit bad = 0; bit got = 0;
    bus.AWADDR = 32'h8; bus.AWVALID = 1'b1; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.WDATA = 32'h4; bus.WSTRB = 4'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL aw_early_ready: READY seen before WVALID, wanted 0"); end
    @(posedge ACLK); #1 bus.WVALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (bus.AWREADY === 1'b1 || bus.WREADY === 1'b1) begin got = 1; break; end
    end
    checks++;
    if (!got || bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) begin
      errors++; $display("FAIL aw_w_together: AWREADY=%b WREADY=%b, wanted 1/1", bus.AWREADY, bus.WREADY);
    end
    @(posedge ACLK); #1 bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge ACLK);
    first = bus.BRESP;
    bad = (bus.BVALID !== 1'b1) || (first !== 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      if (bus.BVALID !== 1'b1 || bus.BRESP !== first) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL b_hold: BVALID=%b BRESP=%b, wanted held 1/00", bus.BVALID, bus.BRESP); end
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1 bus.BREADY = 1'b0;
    @(negedge ACLK);
    checks++;
    if (bus.BVALID !== 1'b0) begin errors++; $display("FAIL b_drop: BVALID=%b, wanted 0", bus.BVALID); end
  endtask

  task automatic test_busy_write();
    logic [31:0] d; logic [1:0] r, b;
    SPI_MISO = 1'b0;
    clear_mon();
    axi_write(32'h0, 32'hA5, 4'h1, b);
    axi_read(32'h4, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL busy_stat: got %h, wanted 1", d); end
    axi_write(32'h0, 32'h3C, 4'h1, b);
    checks++;
    if (b !== 2'b10) begin errors++; $display("FAIL busy_bresp: got %b, wanted 10", b); end
    wait_xfer("busy");
    checks++;
    if (mosi_byte() !== 8'hA5) begin errors++; $display("FAIL busy_mosi: got %h, wanted a5", mosi_byte()); end
    axi_read(32'h0, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL busy_rx: got %h, wanted 0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r, b;
    axi_read(32'h20, d, r);
    checks++;
    if ({r, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rd_0x20: resp=%b data=%h, wanted 10/0", r, d); end
    axi_read(32'hC, d, r);
    checks++;
    if ({r, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rd_0xc: resp=%b data=%h, wanted 10/0", r, d); end
    axi_write(32'h20, 32'h1, 4'hF, b);
    checks++;
    if (b !== 2'b10) begin errors++; $display("FAIL wr_0x20: got %b, wanted 10", b); end
    axi_write(32'h9, 32'h1, 4'hF, b);
    checks++;
    if (b !== 2'b10) begin errors++; $display("FAIL wr_0x9: got %b, wanted 10", b); end
    axi_write(32'h4, 32'h3, 4'hF, b);
    checks++;
    if (b !== 2'b00) begin errors++; $display("FAIL wr_stat: got %b, wanted 00", b); end
  endtask

  task automatic test_div1();
    logic [31:0] d; logic [1:0] r, b;
    axi_write(32'h8, 32'h1, 4'h1, b);
    axi_read(32'h8, d, r);
    checks++;
    if ({b, d} !== {2'b00, 32'h1}) begin errors++; $display("FAIL ctrl_rw: bresp=%b data=%h, wanted 00/1", b, d); end
    SPI_MISO = 1'b1;
    clear_mon();
    axi_write(32'h0, 32'h5A, 4'h1, b);
    wait_xfer("div1");
    checks++;
    if (!spacing_ok(20) || edge_t[0] - hs_time != 20) begin
      errors++; $display("FAIL div1_halfperiod: edges=%0d first=%0t, wanted 16 edges 20 apart", edge_t.size(), edge_t[0] - hs_time);
    end
    checks++;
    if (mosi_byte() !== 8'h5A) begin errors++; $display("FAIL div1_mosi: got %h, wanted 5a", mosi_byte()); end
    // Disabled byte lane: accepted with OKAY but launches nothing.
    clear_mon();
    axi_write(32'h0, 32'hFF, 4'hE, b);
    repeat (10) @(negedge ACLK);
    checks++;
    if (b !== 2'b00 || edge_t.size() != 0) begin
      errors++; $display("FAIL strb0: bresp=%b edges=%0d, wanted 00/0", b, edge_t.size());
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic [1:0] r, b;
    axi_write(32'h0, 32'hFF, 4'h1, b);
    repeat (5) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(posedge ACLK); #1 ARESETn = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({SPI_SCK, SPI_MOSI} !== 2'b00) begin errors++; $display("FAIL abort_pins: SCK=%b MOSI=%b, wanted 0/0", SPI_SCK, SPI_MOSI); end
    axi_read(32'h4, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL abort_stat: got %h, wanted 0", d); end
    axi_read(32'h8, d, r);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL abort_div: got %h, wanted 4", d); end
  endtask

  initial begin
    ARESETn = 1'b1; SPI_MISO = 1'b0;
    bus.AWVALID = 0; bus.AWADDR = '0; bus.AWPROT = '0;
    bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARADDR = '0; bus.ARPROT = '0; bus.RREADY = 0;
    test_reset();
    test_same_cycle();
    test_basic_a5();
    test_aw_before_w();
    test_busy_write();
    test_unmapped();
    test_div1();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
